bus_master_port: RTL and testbench
==================================

# bus_master_port

Bus-side master port that sits directly downstream of the bridge address converter. It accepts one parallel request per transaction: a bus address already mapped by the converter, write data, and direction. It then arbitrates for the serial system bus, shifts the address and write data out LSB-first, collects serial read data, and returns a single-cycle response with error status. One transaction is outstanding at a time.

## Interface
Parameters:
- ADDR_WIDTH, 16, bus address width; matches the converter's bus address output.
- DATA_WIDTH, 8, transaction data width.
- TIMEOUT, 64, maximum consecutive wait cycles for slave ack or read bit before the transaction is aborted; must be ≥ 1.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  port idle, request accepted this cycle if req_valid.
- req_addr  in  ADDR_WIDTH  mapped bus address.
- req_wdata  in  DATA_WIDTH  write data.
- req_write  in  1  1 = write, 0 = read.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_valid; 1 = timeout or grant loss.
- rsp_rdata  out  DATA_WIDTH  read data; updated only on successful read completion.
- mbreq  out  1  arbitration request.
- mbgrant  in  1  arbiter grant.
- mmode  out  1  registered req_write, held for the whole transaction.
- mvalid  out  1  mdata carries a valid serial bit.
- mdata  out  1  serial address/write-data bit.
- sack  in  1  addressed slave acknowledges the address.
- srvalid  in  1  srdata carries a valid read bit.
- srdata  in  1  serial read-data bit.

## Operation
- States: IDLE, REQ, ADDR, WAIT_ACK, WDATA, RDATA, DONE.
- IDLE: req_ready=1. On req_valid, capture addr, wdata, and write into shadow registers, then go to REQ. Inputs are ignored in all other states.
- REQ: mbreq=1. On mbgrant=1, go to ADDR and clear the bit counter. No timeout applies in REQ.
- ADDR: mvalid=1, mdata=addr[cnt], cnt counts 0..ADDR_WIDTH-1. After the last bit, go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK: mvalid=0. On sack=1, go to WDATA if write, else RDATA. If TIMEOUT cycles pass without sack, go to DONE with err=1.
- WDATA: mvalid=1, mdata=wdata[cnt], DATA_WIDTH cycles, then go to DONE with err=0.
- RDATA: each cycle with srvalid=1 shifts srdata into bit cnt (LSB-first). After bit DATA_WIDTH-1, go to DONE with err=0. The timeout counter restarts on every received bit; TIMEOUT idle cycles force DONE with err=1.
- Grant loss: if mbgrant=0 in any of ADDR, WAIT_ACK, WDATA, or RDATA, go to DONE with err=1 next cycle. mvalid drops immediately, and no further bits are driven.
- DONE: rsp_valid=1, rsp_err=err, mbreq=0. On a read with err=0, rsp_rdata takes the assembled byte. Return to IDLE.
- mbreq is 1 in REQ, ADDR, WAIT_ACK, WDATA, and RDATA; 0 in IDLE and DONE.
- Counters are sized $clog2(max(ADDR_WIDTH, DATA_WIDTH, TIMEOUT+1)) and never wrap within a state.

## Timing
- Reset values (async, immediate): state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mbreq=0, mmode=0, mvalid=0, mdata=0. Reset mid-transaction aborts with no response pulse.
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.
- Write latency, with grant and sack on first opportunity, where accept is cycle 0:
  - REQ in cycle 1.
  - ADDR bits in cycles 2..ADDR_WIDTH+1.
  - WAIT_ACK in cycle ADDR_WIDTH+2.
  - WDATA in the next DATA_WIDTH cycles.
  - rsp_valid in cycle ADDR_WIDTH+DATA_WIDTH+3, which is 27 at the defaults.
- Read latency is the same, with RDATA stretched by any cycles where srvalid=0.
- req_ready returns to 1 in the cycle after rsp_valid. Back-to-back requests are therefore separated by at least one idle cycle.
- sack sampled on the same cycle as the ADDR last bit is ignored; sack is only sampled in WAIT_ACK.

## Test plan
- Write, addr=0x1ABC, wdata=0xA5, grant held, sack on first WAIT_ACK cycle -> mdata sequence is 0x1ABC LSB-first then 0xA5 LSB-first, mmode=1, rsp_valid at cycle 27, rsp_err=0.
- Read, addr=0x0123, srdata bits of 0x3C with srvalid gapped every other cycle -> rsp_rdata=0x3C, rsp_err=0, rsp_valid one cycle after the 8th valid bit.
- Read, sack never asserted, TIMEOUT=4 -> rsp_valid with rsp_err=1 exactly 4 cycles after entering WAIT_ACK; rsp_rdata keeps its previous value; mbreq drops.
- Grant held off 10 cycles in REQ -> mbreq steady at 1, no timeout, address starts the cycle after grant sampled.
- Grant dropped during the 5th address bit -> mvalid=0 the next cycle, rsp_err=1 pulse, return to IDLE with req_ready=1.
- rstn asserted mid-WDATA, released, new request issued -> all outputs at reset values during reset, no rsp_valid, and the new transaction completes normally.

Source files
------------

// File: rtl/bus_master_port.sv
// Serial system-bus master port: one parallel request in, address/write data shifted out LSB-first,
// serial read data assembled, single-cycle response with error status out.
module bus_master_port #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic                  req_write,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  mbreq,
   input  logic                  mbgrant,
   output logic                  mmode,
   output logic                  mvalid,
   output logic                  mdata,
   input  logic                  sack,
   input  logic                  srvalid,
   input  logic                  srdata
);

   localparam int MAXAD = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int MAXV  = (MAXAD > TIMEOUT + 1) ? MAXAD : TIMEOUT + 1;
   localparam int CW    = $clog2(MAXV);
   localparam logic [CW-1:0] ALAST = CW'(ADDR_WIDTH - 1);
   localparam logic [CW-1:0] DLAST = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, REQ, ADDR, WAIT_ACK, WDATA, RDATA, DONE} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d, tcnt_q, tcnt_d;
   logic [ADDR_WIDTH-1:0] ash_q, ash_d;
   logic [DATA_WIDTH-1:0] wsh_q, wsh_d, rbuf_q, rbuf_d;
   logic                  write_q, write_d, err_q, err_d, bit_d;
   logic                  ready_q, rspValid_q, rspErr_q, mbreq_q, mvalid_q, mdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   // Address and write data leave through shift registers, so the next serial bit is always bit 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      ash_d   = ash_q;
      wsh_d   = wsh_q;
      rbuf_d  = rbuf_q;
      write_d = write_q;
      err_d   = err_q;
      bit_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               ash_d   = req_addr;
               wsh_d   = req_wdata;
               write_d = req_write;
               rbuf_d  = '0;
               err_d   = 1'b0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (mbgrant) begin
               cnt_d   = '0;
               bit_d   = ash_q[0];
               ash_d   = ash_q >> 1;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (!mbgrant) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else if (cnt_q == ALAST) begin
               tcnt_d  = '0;
               state_d = WAIT_ACK;
            end else begin
               cnt_d = cnt_q + CW'(1);
               bit_d = ash_q[0];
               ash_d = ash_q >> 1;
            end
         end
         WAIT_ACK: begin
            if (!mbgrant) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else if (sack) begin
               cnt_d  = '0;
               tcnt_d = '0;
               if (write_q) begin
                  bit_d   = wsh_q[0];
                  wsh_d   = wsh_q >> 1;
                  state_d = WDATA;
               end else begin
                  state_d = RDATA;
               end
            end else if (tcnt_q == TLAST) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               tcnt_d = tcnt_q + CW'(1);
            end
         end
         WDATA: begin
            if (!mbgrant) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else if (cnt_q == DLAST) begin
               err_d   = 1'b0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               bit_d = wsh_q[0];
               wsh_d = wsh_q >> 1;
            end
         end
         RDATA: begin
            // Read bits enter at the top so the first (LSB) bit lands in bit 0 after the last shift.
            if (!mbgrant) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else if (srvalid) begin
               rbuf_d = {srdata, rbuf_q[DATA_WIDTH-1:1]};
               tcnt_d = '0;
               if (cnt_q == DLAST) begin
                  err_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else if (tcnt_q == TLAST) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               tcnt_d = tcnt_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tcnt_q     <= '0;
         ash_q      <= '0;
         wsh_q      <= '0;
         rbuf_q     <= '0;
         write_q    <= 1'b0;
         err_q      <= 1'b0;
         ready_q    <= 1'b1;
         rspValid_q <= 1'b0;
         rspErr_q   <= 1'b0;
         rdata_q    <= '0;
         mbreq_q    <= 1'b0;
         mvalid_q   <= 1'b0;
         mdata_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tcnt_q     <= tcnt_d;
         ash_q      <= ash_d;
         wsh_q      <= wsh_d;
         rbuf_q     <= rbuf_d;
         write_q    <= write_d;
         err_q      <= err_d;
         ready_q    <= (state_d == IDLE);
         rspValid_q <= (state_d == DONE);
         rspErr_q   <= (state_d == DONE) && err_d;
         mbreq_q    <= (state_d inside {REQ, ADDR, WAIT_ACK, WDATA, RDATA});
         mvalid_q   <= (state_d == ADDR) || (state_d == WDATA);
         mdata_q    <= bit_d;
         if ((state_d == DONE) && !write_q && !err_d) begin
            rdata_q <= rbuf_d;
         end
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rspValid_q;
   assign rsp_err   = rspErr_q;
   assign rsp_rdata = rdata_q;
   assign mbreq     = mbreq_q;
   assign mmode     = write_q;
   assign mvalid    = mvalid_q;
   assign mdata     = mdata_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: a transaction-timeline model predicts every output per cycle,
// and per-transaction literal expectations pin the model.
module tb_bus_master_port;

   localparam int AW   = 16;
   localparam int DW   = 8;
   localparam int TO   = 4;
   localparam int MAXC = 128;

   logic          clk = 1'b0;
   logic          rstn;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          req_write;
   logic          rsp_valid;
   logic          rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          mbreq;
   logic          mbgrant;
   logic          mmode;
   logic          mvalid;
   logic          mdata;
   logic          sack;
   logic          srvalid;
   logic          srdata;

   always #5 clk = ~clk;

   bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_write(req_write),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .mbreq(mbreq), .mbgrant(mbgrant), .mmode(mmode), .mvalid(mvalid), .mdata(mdata),
      .sack(sack), .srvalid(srvalid), .srdata(srdata)
   );

   typedef struct {
      logic          ready;
      logic          rspValid;
      logic          rspErr;
      logic [DW-1:0] rdata;
      logic          mbreq;
      logic          mmode;
      logic          mvalid;
      logic          mdata;
      string         name;
      int            cyc;
   } outVec_t;

   outVec_t expQ[$];
   outVec_t curExp;
   outVec_t tl[MAXC];
   logic    gnt[MAXC];
   logic    sk[MAXC];
   logic    sv[MAXC];
   logic    sd[MAXC];

   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] modelRdata = '0;
   logic          modelMode  = 1'b0;

   task automatic checkOutput(input string name, input int cyc, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic outVec_t resetVec(input string name, input int cyc);
      outVec_t v;
      v.ready = 1'b1; v.rspValid = 1'b0; v.rspErr = 1'b0; v.rdata = '0;
      v.mbreq = 1'b0; v.mmode = 1'b0; v.mvalid = 1'b0; v.mdata = 1'b0;
      v.name = name; v.cyc = cyc;
      return v;
   endfunction

   // Every cycle with a pending prediction is compared field by field, mid-cycle.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         curExp = expQ.pop_front();
         checkOutput({curExp.name, " req_ready"}, curExp.cyc, 32'(req_ready), 32'(curExp.ready));
         checkOutput({curExp.name, " rsp_valid"}, curExp.cyc, 32'(rsp_valid), 32'(curExp.rspValid));
         checkOutput({curExp.name, " rsp_err"},   curExp.cyc, 32'(rsp_err),   32'(curExp.rspErr));
         checkOutput({curExp.name, " rsp_rdata"}, curExp.cyc, 32'(rsp_rdata), 32'(curExp.rdata));
         checkOutput({curExp.name, " mbreq"},     curExp.cyc, 32'(mbreq),     32'(curExp.mbreq));
         checkOutput({curExp.name, " mmode"},     curExp.cyc, 32'(mmode),     32'(curExp.mmode));
         checkOutput({curExp.name, " mvalid"},    curExp.cyc, 32'(mvalid),    32'(curExp.mvalid));
         checkOutput({curExp.name, " mdata"},     curExp.cyc, 32'(mdata),     32'(curExp.mdata));
      end
   end

   // Builds the cycle timeline of one transaction (cycle 0 = accept) from the documented latencies,
   // drives it, and checks the observed response against hand-computed literals.
   task automatic applyStimulus(input string name, input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                                input int gdelay, input int sackDelay, input logic earlySack,
                                input int gap, input int dropBit, input int resetAt,
                                input int expDone, input logic expErr, input int expRdata,
                                input logic [31:0] expSerial);
      int            addrStart, waitStart, dataStart, done, len, nBits, obsDone, vc;
      logic          err, obsErr;
      logic [DW-1:0] obsRdata;
      logic [31:0]   obsSerial;
      addrStart = 2 + gdelay;
      waitStart = addrStart + AW;
      dataStart = 0;
      if (dropBit >= 0) begin
         done = addrStart + dropBit + 1;
         err  = 1'b1;
      end else if (sackDelay >= TO) begin
         done = waitStart + TO;
         err  = 1'b1;
      end else begin
         dataStart = waitStart + sackDelay + 1;
         done      = wr ? dataStart + DW : dataStart + DW * (gap + 1);
         err       = 1'b0;
      end
      len = done + 2;
      for (int c = 0; c < len; c++) begin
         tl[c].ready    = (c == 0) || (c == done + 1);
         tl[c].rspValid = (c == done);
         tl[c].rspErr   = (c == done) && err;
         tl[c].rdata    = (!wr && !err && c >= done) ? rdata : modelRdata;
         tl[c].mbreq    = (c >= 1) && (c < done);
         tl[c].mmode    = (c == 0) ? modelMode : wr;
         tl[c].mvalid   = 1'b0;
         tl[c].mdata    = 1'b0;
         tl[c].name     = name;
         tl[c].cyc      = c;
         gnt[c] = (c >= 1 + gdelay) && (c < done);
         sk[c]  = 1'b0;
         sv[c]  = 1'b0;
         sd[c]  = 1'b0;
      end
      for (int i = 0; i < AW; i++) begin
         if (dropBit < 0 || i <= dropBit) begin
            tl[addrStart + i].mvalid = 1'b1;
            tl[addrStart + i].mdata  = addr[i];
         end
      end
      if (dropBit >= 0) begin
         gnt[addrStart + dropBit] = 1'b0;
      end else begin
         if (earlySack) sk[waitStart - 1] = 1'b1;
         if (sackDelay < TO) begin
            sk[waitStart + sackDelay] = 1'b1;
            for (int j = 0; j < DW; j++) begin
               if (wr) begin
                  tl[dataStart + j].mvalid = 1'b1;
                  tl[dataStart + j].mdata  = wdata[j];
               end else begin
                  vc = dataStart + j * (gap + 1);
                  for (int k = 0; k < gap; k++) sd[vc + k] = ~rdata[j];
                  sv[vc + gap] = 1'b1;
                  sd[vc + gap] = rdata[j];
               end
            end
         end
      end
      if (resetAt >= 0) begin
         len = resetAt + 3;
         for (int c = resetAt; c < len; c++) begin
            tl[c] = resetVec(name, c);
            gnt[c] = 1'b0; sk[c] = 1'b0; sv[c] = 1'b0; sd[c] = 1'b0;
         end
      end

      obsDone = -1; obsErr = 1'b0; obsRdata = '0; obsSerial = '0; nBits = 0;
      for (int c = 0; c < len; c++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) begin
            obsDone  = c;
            obsErr   = rsp_err;
            obsRdata = rsp_rdata;
         end
         if (mvalid && nBits < 32) begin
            obsSerial[nBits] = mdata;
            nBits++;
         end
         rstn      = !(resetAt >= 0 && c >= resetAt && c < resetAt + 2);
         req_valid = (c == 0);
         req_addr  = (c == 0) ? addr : ~addr;
         req_wdata = (c == 0) ? wdata : ~wdata;
         req_write = (c == 0) ? wr : ~wr;
         mbgrant   = gnt[c];
         sack      = sk[c];
         srvalid   = sv[c];
         srdata    = sd[c];
         expQ.push_back(tl[c]);
      end

      if (resetAt >= 0) begin
         modelRdata = '0;
         modelMode  = 1'b0;
      end else begin
         modelMode = wr;
         if (!wr && !err) modelRdata = rdata;
      end
      checkOutput({name, " rsp_cycle"}, len, 32'(obsDone), 32'(expDone));
      checkOutput({name, " rsp_err_lit"}, len, 32'(obsErr), 32'(expErr));
      if (expRdata >= 0) checkOutput({name, " rdata_lit"}, len, 32'(obsRdata), 32'(expRdata));
      checkOutput({name, " serial_bits"}, len, obsSerial, expSerial);
   endtask

   initial begin
      rstn = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
      mbgrant = 1'b0; sack = 1'b0; srvalid = 1'b0; srdata = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         if (c == 2) rstn = 1'b1;
         expQ.push_back(resetVec("reset", c));
      end
      //            name   wr    addr      wdata  rdata  gdl sdl early gap drop rst done err  rdat  serial
      applyStimulus("W1", 1'b1, 16'h1ABC, 8'hA5, 8'h00, 0,  0,  1'b0, 0,  -1,  -1, 27, 1'b0, -1,   32'h00A51ABC);
      applyStimulus("R1", 1'b0, 16'h0123, 8'h00, 8'h3C, 0,  0,  1'b0, 1,  -1,  -1, 35, 1'b0, 'h3C, 32'h00000123);
      applyStimulus("T1", 1'b0, 16'h0F0F, 8'h00, 8'hFF, 0,  99, 1'b0, 0,  -1,  -1, 22, 1'b1, 'h3C, 32'h00000F0F);
      applyStimulus("G1", 1'b1, 16'h00FF, 8'h5A, 8'h00, 10, 0,  1'b0, 0,  -1,  -1, 37, 1'b0, -1,   32'h005A00FF);
      applyStimulus("D1", 1'b1, 16'h1ABC, 8'hFF, 8'h00, 0,  0,  1'b0, 0,  4,   -1, 7,  1'b1, -1,   32'h0000001C);
      applyStimulus("X1", 1'b1, 16'h4321, 8'h96, 8'h00, 0,  0,  1'b0, 0,  -1,  22, -1, 1'b0, -1,   32'h00064321);
      applyStimulus("W2", 1'b1, 16'h8001, 8'h3C, 8'h00, 0,  2,  1'b1, 0,  -1,  -1, 29, 1'b0, -1,   32'h003C8001);
      applyStimulus("R2", 1'b0, 16'h7FFE, 8'h00, 8'hC5, 0,  3,  1'b0, 0,  -1,  -1, 30, 1'b0, 'hC5, 32'h00007FFE);
      repeat (3) @(negedge clk);
      checkOutput("queue_drained", 0, 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog cyc=0 got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
